// File: rtl/udp_reg_master.sv
// Single-outstanding register master at the head of the UDP register ring.
// Launches one CPU request per transaction and completes it on return, tag miss or timeout.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module udp_reg_master #(
   parameter int UDP_REG_SRC_WIDTH = 2,
   parameter int SRC_ADDR          = 0,
   parameter int TIMEOUT           = 200,
   parameter int TIMER_WIDTH       = 8
) (
   input  logic                                clk,
   input  logic                                reset,

   input  logic                                core_reg_req,
   input  logic                                core_reg_rd_wr_L,
   input  logic [`UDP_REG_ADDR_WIDTH-1:0]      core_reg_addr,
   input  logic [`CPCI_NF2_DATA_WIDTH-1:0]     core_reg_wr_data,
   output logic                                core_reg_busy,
   output logic                                core_reg_ack,
   output logic [`CPCI_NF2_DATA_WIDTH-1:0]     core_reg_rd_data,
   output logic                                core_reg_nack,
   output logic                                core_reg_timeout,

   output logic                                reg_req_out,
   output logic                                reg_ack_out,
   output logic                                reg_rd_wr_L_out,
   output logic [`UDP_REG_ADDR_WIDTH-1:0]      reg_addr_out,
   output logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_out,
   output logic [UDP_REG_SRC_WIDTH-1:0]        reg_src_out,

   input  logic                                reg_req_in,
   input  logic                                reg_ack_in,
   input  logic                                reg_rd_wr_L_in,
   input  logic [`UDP_REG_ADDR_WIDTH-1:0]      reg_addr_in,
   input  logic [`CPCI_NF2_DATA_WIDTH-1:0]     reg_data_in,
   input  logic [UDP_REG_SRC_WIDTH-1:0]        reg_src_in
);

   // state | meaning
   // IDLE  | waiting for a CPU request
   // WAIT  | request launched on ring, watching the tail for its return
   // DONE  | one-cycle completion pulse to the CPU side

   localparam int AW = `UDP_REG_ADDR_WIDTH;
   localparam int DW = `CPCI_NF2_DATA_WIDTH;
   localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID    = UDP_REG_SRC_WIDTH'(SRC_ADDR);
   localparam logic [TIMER_WIDTH-1:0]       TIMER_END = TIMER_WIDTH'(TIMEOUT - 1);
   localparam logic [DW-1:0]                DEAD_DATA = DW'(32'hDEAD_BEEF);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t                 state;
   logic [TIMER_WIDTH-1:0] timer;
   logic                   req_rd_wr_L;
   logic [AW-1:0]          req_addr;
   logic [DW-1:0]          req_wr_data;
   logic                   match;

   // The tail's rd_wr_L is not needed: the latched copy decides the completion data.
   logic unused_rd_wr_L_in;
   assign unused_rd_wr_L_in = reg_rd_wr_L_in;

   assign match = reg_req_in && (reg_src_in == SRC_ID) && (reg_addr_in == req_addr);

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         timer            <= '0;
         req_rd_wr_L      <= 1'b0;
         req_addr         <= '0;
         req_wr_data      <= '0;
         core_reg_busy    <= 1'b0;
         core_reg_ack     <= 1'b0;
         core_reg_rd_data <= '0;
         core_reg_nack    <= 1'b0;
         core_reg_timeout <= 1'b0;
         reg_req_out      <= 1'b0;
         reg_ack_out      <= 1'b0;
         reg_rd_wr_L_out  <= 1'b0;
         reg_addr_out     <= '0;
         reg_data_out     <= '0;
         reg_src_out      <= '0;
      end else begin
         reg_req_out      <= 1'b0;
         reg_ack_out      <= 1'b0;
         reg_rd_wr_L_out  <= 1'b0;
         reg_addr_out     <= '0;
         reg_data_out     <= '0;
         reg_src_out      <= '0;
         core_reg_ack     <= 1'b0;
         core_reg_nack    <= 1'b0;
         core_reg_timeout <= 1'b0;

         case (state)
            IDLE: begin
               if (core_reg_req) begin
                  state           <= WAIT;
                  timer           <= '0;
                  req_rd_wr_L     <= core_reg_rd_wr_L;
                  req_addr        <= core_reg_addr;
                  req_wr_data     <= core_reg_wr_data;
                  core_reg_busy   <= 1'b1;
                  reg_req_out     <= 1'b1;
                  reg_rd_wr_L_out <= core_reg_rd_wr_L;
                  reg_addr_out    <= core_reg_addr;
                  reg_data_out    <= core_reg_rd_wr_L ? '0 : core_reg_wr_data;
                  reg_src_out     <= SRC_ID;
               end
            end

            WAIT: begin
               if (match) begin
                  state         <= DONE;
                  core_reg_ack  <= 1'b1;
                  core_reg_nack <= ~reg_ack_in;
                  if (!req_rd_wr_L)
                     core_reg_rd_data <= '0;
                  else if (reg_ack_in)
                     core_reg_rd_data <= reg_data_in;
                  else
                     core_reg_rd_data <= DEAD_DATA;
               end else if (timer == TIMER_END) begin
                  state            <= DONE;
                  core_reg_ack     <= 1'b1;
                  core_reg_timeout <= 1'b1;
                  core_reg_rd_data <= DEAD_DATA;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            DONE: begin
               state         <= IDLE;
               core_reg_busy <= 1'b0;
            end

            default: begin
               state         <= IDLE;
               core_reg_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_udp_reg_master.sv
// Bench for udp_reg_master: ring of one registered register block, or a manually driven tail.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_udp_reg_master;
   localparam int AW = `UDP_REG_ADDR_WIDTH;
   localparam int DW = `CPCI_NF2_DATA_WIDTH;
   localparam int SW = 2;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic reset;
   logic core_reg_req, core_reg_rd_wr_L;
   logic [AW-1:0] core_reg_addr;
   logic [DW-1:0] core_reg_wr_data;
   logic core_reg_busy, core_reg_ack, core_reg_nack, core_reg_timeout;
   logic [DW-1:0] core_reg_rd_data;
   logic reg_req_out, reg_ack_out, reg_rd_wr_L_out;
   logic [AW-1:0] reg_addr_out;
   logic [DW-1:0] reg_data_out;
   logic [SW-1:0] reg_src_out;
   logic reg_req_in, reg_ack_in, reg_rd_wr_L_in;
   logic [AW-1:0] reg_addr_in;
   logic [DW-1:0] reg_data_in;
   logic [SW-1:0] reg_src_in;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   udp_reg_master #(.UDP_REG_SRC_WIDTH(SW), .SRC_ADDR(0), .TIMEOUT(TMO), .TIMER_WIDTH(8)) dut (
      .clk(clk), .reset(reset),
      .core_reg_req(core_reg_req), .core_reg_rd_wr_L(core_reg_rd_wr_L),
      .core_reg_addr(core_reg_addr), .core_reg_wr_data(core_reg_wr_data),
      .core_reg_busy(core_reg_busy), .core_reg_ack(core_reg_ack),
      .core_reg_rd_data(core_reg_rd_data), .core_reg_nack(core_reg_nack),
      .core_reg_timeout(core_reg_timeout),
      .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
      .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
      .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
      .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in));

   // Ring: one registered register block (tag 0, regs 0..3), or a hand-driven tail.
   logic manual;
   logic man_req, man_ack, man_rw;
   logic [AW-1:0] man_addr;
   logic [DW-1:0] man_data;
   logic [SW-1:0] man_src;
   logic blk_req, blk_ack, blk_rw;
   logic [AW-1:0] blk_addr;
   logic [DW-1:0] blk_data;
   logic [SW-1:0] blk_src;
   logic [DW-1:0] ring_regs [4];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) ring_regs[i] <= 32'hCAFE_0000 + i;
         blk_req <= 0; blk_ack <= 0; blk_rw <= 0; blk_addr <= '0; blk_data <= '0; blk_src <= '0;
      end else begin
         blk_req  <= reg_req_out;
         blk_rw   <= reg_rd_wr_L_out;
         blk_addr <= reg_addr_out;
         blk_src  <= reg_src_out;
         if (reg_req_out && !manual && reg_addr_out < 4) begin
            blk_ack <= 1'b1;
            if (reg_rd_wr_L_out) blk_data <= ring_regs[reg_addr_out[1:0]];
            else begin
               ring_regs[reg_addr_out[1:0]] <= reg_data_out;
               blk_data <= reg_data_out;
            end
         end else begin
            blk_ack  <= reg_ack_out;
            blk_data <= reg_data_out;
         end
      end
   end

   assign reg_req_in     = manual ? man_req  : blk_req;
   assign reg_ack_in     = manual ? man_ack  : blk_ack;
   assign reg_rd_wr_L_in = manual ? man_rw   : blk_rw;
   assign reg_addr_in    = manual ? man_addr : blk_addr;
   assign reg_data_in    = manual ? man_data : blk_data;
   assign reg_src_in     = manual ? man_src  : blk_src;

   // Reference model: register contents and completion rules.
   logic [DW-1:0] mdl [4];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic mdl_reset();
      for (int i = 0; i < 4; i++) mdl[i] = 32'hCAFE_0000 + i;
   endtask

   // Drive one request so it is sampled at the next edge (E0); returns at E0+1ns.
   task automatic launch(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      core_reg_req = 1; core_reg_rd_wr_L = rd; core_reg_addr = a; core_reg_wr_data = d;
      @(posedge clk); #1;
      core_reg_req = 0;
      chk("head_req", reg_req_out, 1);
      chk("head_src", reg_src_out, 0);
      chk("head_addr", reg_addr_out, a);
      chk("head_rw", reg_rd_wr_L_out, rd);
      chk("head_data", reg_data_out, rd ? 0 : d);
      chk("busy_launch", core_reg_busy, 1);
   endtask

   // Count edges after E0 until ack is seen; bounded.
   task automatic wait_ack(output int lat);
      lat = 0;
      while (!core_reg_ack && lat < 100) begin
         @(posedge clk); #1; lat++;
         if (lat == 1) chk("head_one_cycle", reg_req_out, 0);
      end
      if (!core_reg_ack) chk("ack_bound", 0, 1);
   endtask

   // Full transaction against the register block, expectations from the model.
   task automatic block_txn(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int lat;
      bit hit;
      logic [DW-1:0] exp_data;
      hit = (a < 4);
      if (!rd) exp_data = 0;
      else if (hit) exp_data = mdl[a[1:0]];
      else exp_data = 32'hDEAD_BEEF;
      if (!rd && hit) mdl[a[1:0]] = d;
      launch(rd, a, d);
      wait_ack(lat);
      chk("latency", lat, 2);
      chk("rd_data", core_reg_rd_data, exp_data);
      chk("nack", core_reg_nack, !hit);
      chk("timeout_flag", core_reg_timeout, 0);
      chk("busy_done", core_reg_busy, 1);
      @(posedge clk); #1;
      chk("ack_pulse", core_reg_ack, 0);
      chk("busy_idle", core_reg_busy, 0);
      chk("rd_data_hold", core_reg_rd_data, exp_data);
   endtask

   task automatic inject(input logic [SW-1:0] s, input logic [AW-1:0] a, input bit ack, input logic [DW-1:0] d);
      @(negedge clk);
      man_req = 1; man_src = s; man_addr = a; man_ack = ack; man_data = d; man_rw = 1;
      @(negedge clk);
      man_req = 0; man_src = 0; man_addr = 0; man_ack = 0; man_data = 0;
   endtask

   initial begin
      int lat;
      int acks;
      reset = 1; manual = 0;
      core_reg_req = 0; core_reg_rd_wr_L = 0; core_reg_addr = 0; core_reg_wr_data = 0;
      man_req = 0; man_ack = 0; man_rw = 0; man_addr = 0; man_data = 0; man_src = 0;
      mdl_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", core_reg_busy, 0);
      chk("rst_ack", core_reg_ack, 0);
      chk("rst_rd_data", core_reg_rd_data, 0);
      chk("rst_head", {reg_req_out, reg_addr_out, reg_data_out}, 0);
      @(negedge clk); reset = 0;

      // Directed reads/writes through the block
      block_txn(1, 2, 0);
      block_txn(1, 9, 0);
      block_txn(0, 1, 32'h1234_5678);
      block_txn(1, 1, 0);

      // Randomized traffic
      for (int i = 0; i < 20; i++)
         block_txn($urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom);

      // Timeout with dead ring; late matching return ignored
      manual = 1;
      launch(1, 5, 0);
      wait_ack(lat);
      chk("tmo_latency", lat, TMO);
      chk("tmo_flag", core_reg_timeout, 1);
      chk("tmo_nack", core_reg_nack, 0);
      chk("tmo_data", core_reg_rd_data, 32'hDEAD_BEEF);
      repeat (3) @(posedge clk);
      inject(0, 5, 1, 32'h5555_AAAA);
      acks = 0;
      repeat (4) begin @(posedge clk); #1; acks += int'(core_reg_ack); end
      chk("tmo_late_ack", acks, 0);
      chk("tmo_busy", core_reg_busy, 0);

      // Foreign src, stale addr and a second request are all ignored
      launch(1, 3, 0);
      inject(1, 3, 1, 32'h1111_1111);
      inject(0, 2, 1, 32'h2222_2222);
      @(negedge clk);
      core_reg_req = 1; core_reg_rd_wr_L = 0; core_reg_addr = 7; core_reg_wr_data = 32'h7777_7777;
      @(negedge clk); core_reg_req = 0;
      chk("foreign_no_ack", core_reg_ack, 0);
      chk("foreign_busy", core_reg_busy, 1);
      chk("foreign_head", reg_req_out, 0);
      inject(0, 3, 1, 32'h0000_ABCD);
      #2;
      chk("foreign_ack", core_reg_ack, 1);
      chk("foreign_data", core_reg_rd_data, 32'h0000_ABCD);
      chk("foreign_nack", core_reg_nack, 0);
      repeat (2) @(posedge clk);

      // Reset mid-WAIT abandons the request
      launch(1, 6, 0);
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1;
      @(posedge clk); #1;
      chk("midrst_busy", core_reg_busy, 0);
      chk("midrst_rd_data", core_reg_rd_data, 0);
      chk("midrst_ack", {core_reg_ack, core_reg_nack, core_reg_timeout}, 0);
      chk("midrst_head", {reg_req_out, reg_ack_out, reg_src_out, reg_addr_out}, 0);
      @(negedge clk); reset = 0;
      mdl_reset();
      inject(0, 6, 1, 32'h6666_6666);
      acks = 0;
      repeat (4) begin @(posedge clk); #1; acks += int'(core_reg_ack); end
      chk("midrst_late_ack", acks, 0);
      manual = 0;
      block_txn(1, 2, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, observed running expected done");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/udp_reg_master.md
Name: udp_reg_master

Overview:
- Single-outstanding master at the head of the UDP register ring.
- Accepts one CPU-side register request and launches it as a one-cycle request onto the ring, which feeds the chain of generic register blocks.
- Collects the request when it returns at the ring tail and presents the read data and completion status back to the CPU side.
- Guards against a lost request with a cycle timeout.

Parameters:
UDP_REG_SRC_WIDTH, 2, width of the ring source-ID field
SRC_ADDR, 0, source ID stamped on every request launched; only returning requests carrying this ID are matched
TIMEOUT, 200, cycles to wait in WAIT before completing with timeout; 1 <= TIMEOUT < 2^TIMER_WIDTH
TIMER_WIDTH, 8, width of the timeout counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
core_reg_req  in  1  request strobe; sampled only in IDLE
core_reg_rd_wr_L  in  1  1 = read, 0 = write
core_reg_addr  in  `UDP_REG_ADDR_WIDTH  register address (tag + block address)
core_reg_wr_data  in  `CPCI_NF2_DATA_WIDTH  write data
core_reg_busy  out  1  high whenever state != IDLE
core_reg_ack  out  1  one-cycle completion pulse
core_reg_rd_data  out  `CPCI_NF2_DATA_WIDTH  completion data; valid while core_reg_ack = 1
core_reg_nack  out  1  qualifies ack: request returned unclaimed
core_reg_timeout  out  1  qualifies ack: no matching return before TIMEOUT
reg_req_out, reg_ack_out, reg_rd_wr_L_out  out  1 each  ring head control
reg_addr_out  out  `UDP_REG_ADDR_WIDTH  ring head address
reg_data_out  out  `CPCI_NF2_DATA_WIDTH  ring head data
reg_src_out  out  UDP_REG_SRC_WIDTH  ring head source ID
reg_req_in, reg_ack_in, reg_rd_wr_L_in  in  1 each  ring tail control
reg_addr_in  in  `UDP_REG_ADDR_WIDTH  ring tail address
reg_data_in  in  `CPCI_NF2_DATA_WIDTH  ring tail data
reg_src_in  in  UDP_REG_SRC_WIDTH  ring tail source ID

Behaviour:
- All outputs are registered.
- Reset (synchronous, any state):
  - state = IDLE, timer = 0.
  - All outputs 0, including core_reg_rd_data.
  - Latched request fields cleared.
  - A request in flight is abandoned; if it later returns it is discarded, because matching occurs only in WAIT.
- States: IDLE, WAIT, DONE.
- IDLE + core_reg_req = 1 at edge E0:
  - Latch rd_wr_L, addr and wr_data; timer = 0; go to WAIT.
  - Ring head during cycle E0..E1: reg_req_out = 1, reg_ack_out = 0, reg_rd_wr_L_out = latched value, reg_addr_out = latched addr, reg_src_out = SRC_ADDR.
  - reg_data_out = wr_data for writes, 0 for reads.
- Ring head outside the launch cycle: all fields 0, so reg_req_out is high exactly one cycle per request.
- WAIT, per edge:
  - match = reg_req_in & (reg_src_in == SRC_ADDR) & (reg_addr_in == latched addr).
  - On match, go to DONE and set:
    - core_reg_ack = 1 and core_reg_nack = ~reg_ack_in.
    - core_reg_rd_data = reg_data_in for a read with reg_ack_in = 1.
    - core_reg_rd_data = 32'hDEAD_BEEF for a read with reg_ack_in = 0.
    - core_reg_rd_data = 0 for a write.
  - Else if timer == TIMEOUT-1: go to DONE, core_reg_ack = 1, core_reg_timeout = 1, core_reg_rd_data = 32'hDEAD_BEEF.
  - Else timer increments.
  - Match and timeout in the same cycle: match wins.
  - Non-matching ring traffic (foreign src, stale addr, reg_req_in = 0) is ignored and not forwarded.
- Timeout latency: the ack with timeout is high in the cycle starting at edge E0+TIMEOUT.
- DONE:
  - Lasts one cycle; ack, nack and timeout are high only here, then cleared.
  - Next state IDLE; core_reg_rd_data holds its value until the next completion.
- core_reg_req is ignored in WAIT and DONE; no queuing.
- A req still high in IDLE after DONE is a new request.
- Latency:
  - Zero-stage loopback: ack in cycle E1..E2.
  - Each registered ring stage adds 1 cycle.

Test Plan:
1. Ring = one generic register block (TAG 0, REG_ADDR_WIDTH 3, 4 regs, reg2 = 32'hCAFE_0002). Read addr 4'h2 at E0 -> reg_req_out high exactly E0..E1 with src = SRC_ADDR; ack in E2..E3; rd_data = 32'hCAFE_0002; nack = 0, timeout = 0; busy high E0..E3.
2. Same ring, read addr 4'h9 (tag miss) -> ack with nack = 1, rd_data = 32'hDEAD_BEEF, timeout = 0.
3. Write addr 4'h1, data 32'h1234_5678 -> ring head shows reg_data_out = 32'h1234_5678, reg_rd_wr_L_out = 0 for one cycle; ack with rd_data = 0.
4. TIMEOUT = 16, ring tail tied to 0 -> ack with timeout = 1 in cycle starting at E0+16, rd_data = 32'hDEAD_BEEF; a matching return injected at E0+20 is ignored (no second ack).
5. In WAIT, inject a return with src = SRC_ADDR+1 and a return with the wrong addr, and pulse core_reg_req -> no ack, latched request unchanged; a later correct return completes normally.
6. Reset asserted for one cycle mid-WAIT -> all outputs 0 next cycle, busy = 0; the late return is discarded; a fresh read then completes correctly.
